// File: rtl/scan_cmd_parser.sv
// scan_cmd_parser: host UART packet parser that loads the scan-timing
// register set atomically and fires the txdone start strobe.
//
// Ports:
//   sys_clk_100M, reset (async, active-low)
//   rx_data/rx_valid           : received UART byte + 1-cycle strobe
//   tx_data/tx_valid/tx_ready  : ack byte pair out (valid/ready)
//   busy                       : parser not in IDLE
//   txdone                     : START pulse, START_PULSE_LEN cycles
//   err_cnt                    : saturating rejected-packet count
//   frame_nums .. spad_period  : scan-timing parameter registers
`timescale 1ns/1ps
module scan_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES  = 1_000_000,
   parameter int unsigned START_PULSE_LEN = 4
) (
   input  logic        sys_clk_100M,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        txdone,
   output logic [7:0]  err_cnt,
   output logic [7:0]  frame_nums,
   output logic [7:0]  pixel_nums,
   output logic [7:0]  laser_nums,
   output logic [7:0]  spad_nums,
   output logic [8:0]  i_cnt_value,
   output logic [31:0] sig_start_frame,
   output logic [15:0] duty_cycle_frame,
   output logic [31:0] sig_start_spad,
   output logic [15:0] duty_cycle_spad,
   output logic [31:0] sig_start_pixel,
   output logic [15:0] duty_cycle_pixel,
   output logic [31:0] sig_start_laser,
   output logic [15:0] duty_cycle_laser,
   output logic [63:0] frame_period,
   output logic [31:0] pixel_period,
   output logic [31:0] laser_period,
   output logic [31:0] spad_period
);

   localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned PW = $clog2(START_PULSE_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LEN, S_DATA,
      S_CSUM, S_EXEC, S_ACK0, S_ACK1
   } state_t;

   state_t        r_state;
   logic [7:0]    r_cmd;
   logic [7:0]    r_sum;
   logic [7:0]    r_left;
   logic          r_bad;
   logic [63:0]   r_buf;
   logic [GW-1:0] r_gap;
   logic [PW-1:0] r_pulse;

   logic       w_in_pkt;
   logic       w_timeout;
   logic       w_commit;
   logic       w_start;
   logic       w_err_inc;
   logic [4:0] w_map;

   // {known, expected payload length} for a command byte
   function automatic logic [4:0] f_map(input logic [7:0] c);
      case (c)
         8'h01, 8'h02, 8'h03, 8'h04:        return 5'h11;
         8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D: return 5'h12;
         8'h06, 8'h08, 8'h0A, 8'h0C,
         8'h0F, 8'h10, 8'h11:               return 5'h14;
         8'h0E:                             return 5'h18;
         8'h20:                             return 5'h10;
         default:                           return 5'h00;
      endcase
   endfunction

   assign w_map    = f_map(r_cmd);
   assign w_in_pkt = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_timeout = w_in_pkt && !rx_valid &&
                      (r_gap == GW'(TIMEOUT_CYCLES - 1));
   assign w_commit  = (r_state == S_EXEC) && !r_bad;
   assign w_start   = w_commit && (r_cmd == 8'h20);
   assign w_err_inc = ((r_state == S_EXEC) && r_bad) || w_timeout;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge sys_clk_100M or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cmd    <= '0;
         r_sum    <= '0;
         r_left   <= '0;
         r_bad    <= 1'b0;
         r_buf    <= '0;
         r_gap    <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (!w_in_pkt || rx_valid || w_timeout)
            r_gap <= '0;
         else
            r_gap <= r_gap + GW'(1);

         case (r_state)
            S_IDLE: begin
               if (rx_valid && rx_data == 8'hA5) begin
                  r_bad   <= 1'b0;
                  r_state <= S_CMD;
               end
            end
            S_CMD: begin
               if (rx_valid) begin
                  r_cmd   <= rx_data;
                  r_sum   <= rx_data;
                  r_state <= S_LEN;
               end
            end
            S_LEN: begin
               if (rx_valid) begin
                  r_sum  <= r_sum + rx_data;
                  r_left <= rx_data;
                  // bad length still consumes len bytes to keep framing
                  if (!w_map[4] || {4'd0, w_map[3:0]} != rx_data)
                     r_bad <= 1'b1;
                  r_state <= (rx_data == 8'd0) ? S_CSUM : S_DATA;
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  r_buf  <= {r_buf[55:0], rx_data};
                  r_sum  <= r_sum + rx_data;
                  r_left <= r_left - 8'd1;
                  if (r_left == 8'd1)
                     r_state <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (rx_valid) begin
                  if (rx_data != r_sum)
                     r_bad <= 1'b1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               tx_valid <= 1'b1;
               tx_data  <= r_bad ? 8'hEE : 8'h5A;
               r_state  <= S_ACK0;
            end
            S_ACK0: begin
               if (tx_ready) begin
                  tx_data <= r_cmd;
                  r_state <= S_ACK1;
               end
            end
            S_ACK1: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_timeout)
            r_state <= S_IDLE;

         if (w_err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   // Pulse counter is free-running relative to the FSM; a new START
   // reloads it so the pulse simply stretches.
   always_ff @(posedge sys_clk_100M or negedge reset) begin
      if (!reset) begin
         r_pulse <= '0;
         txdone  <= 1'b0;
      end else if (w_start) begin
         r_pulse <= PW'(START_PULSE_LEN - 1);
         txdone  <= 1'b1;
      end else if (r_pulse != '0) begin
         r_pulse <= r_pulse - PW'(1);
      end else begin
         txdone <= 1'b0;
      end
   end

   // Whole register written in one cycle from the shadow buffer
   always_ff @(posedge sys_clk_100M or negedge reset) begin
      if (!reset) begin
         frame_nums       <= '0;
         pixel_nums       <= '0;
         laser_nums       <= '0;
         spad_nums        <= '0;
         i_cnt_value      <= '0;
         sig_start_frame  <= '0;
         duty_cycle_frame <= '0;
         sig_start_spad   <= '0;
         duty_cycle_spad  <= '0;
         sig_start_pixel  <= '0;
         duty_cycle_pixel <= '0;
         sig_start_laser  <= '0;
         duty_cycle_laser <= '0;
         frame_period     <= '0;
         pixel_period     <= '0;
         laser_period     <= '0;
         spad_period      <= '0;
      end else if (w_commit) begin
         case (r_cmd)
            8'h01: frame_nums       <= r_buf[7:0];
            8'h02: pixel_nums       <= r_buf[7:0];
            8'h03: laser_nums       <= r_buf[7:0];
            8'h04: spad_nums        <= r_buf[7:0];
            8'h05: i_cnt_value      <= r_buf[8:0];
            8'h06: sig_start_frame  <= r_buf[31:0];
            8'h07: duty_cycle_frame <= r_buf[15:0];
            8'h08: sig_start_spad   <= r_buf[31:0];
            8'h09: duty_cycle_spad  <= r_buf[15:0];
            8'h0A: sig_start_pixel  <= r_buf[31:0];
            8'h0B: duty_cycle_pixel <= r_buf[15:0];
            8'h0C: sig_start_laser  <= r_buf[31:0];
            8'h0D: duty_cycle_laser <= r_buf[15:0];
            8'h0E: frame_period     <= r_buf;
            8'h0F: pixel_period     <= r_buf[31:0];
            8'h10: laser_period     <= r_buf[31:0];
            8'h11: spad_period      <= r_buf[31:0];
            default: ;
         endcase
      end
   end

endmodule
